// File: rtl/issue_controller_pkg.sv
// issue_controller_pkg
//   Shared definitions for the issue-stage front end:
//   - internal opcode enum values (lui=1 .. andr=37, 0 = illegal)
//   - RV32I major opcodes
//   - issue controller FSM state encoding
//   - is_branch helper
package issue_controller_pkg;

   // Internal opcode enum (7-bit).
   localparam logic [6:0] OP_ILLEGAL = 7'd0;
   localparam logic [6:0] OP_LUI   = 7'd1,  OP_AUIPC = 7'd2,  OP_JAL   = 7'd3,  OP_JALR  = 7'd4;
   localparam logic [6:0] OP_BEQ   = 7'd5,  OP_BNE   = 7'd6,  OP_BLT   = 7'd7,  OP_BGE   = 7'd8;
   localparam logic [6:0] OP_BLTU  = 7'd9,  OP_BGEU  = 7'd10;
   localparam logic [6:0] OP_LB    = 7'd11, OP_LH    = 7'd12, OP_LW    = 7'd13, OP_LBU   = 7'd14;
   localparam logic [6:0] OP_LHU   = 7'd15;
   localparam logic [6:0] OP_SB    = 7'd16, OP_SH    = 7'd17, OP_SW    = 7'd18;
   localparam logic [6:0] OP_ADDI  = 7'd19, OP_SLTI  = 7'd20, OP_SLTIU = 7'd21, OP_XORI  = 7'd22;
   localparam logic [6:0] OP_ORI   = 7'd23, OP_ANDI  = 7'd24, OP_SLLI  = 7'd25, OP_SRLI  = 7'd26;
   localparam logic [6:0] OP_SRAI  = 7'd27;
   localparam logic [6:0] OP_ADD   = 7'd28, OP_SUB   = 7'd29, OP_SLL   = 7'd30, OP_SLT   = 7'd31;
   localparam logic [6:0] OP_SLTU  = 7'd32, OP_XOR   = 7'd33, OP_SRL   = 7'd34, OP_SRA   = 7'd35;
   localparam logic [6:0] OP_OR    = 7'd36, OP_AND   = 7'd37;

   // RV32I major opcodes (inst[6:0]).
   localparam logic [6:0] MAJ_LUI    = 7'b0110111;
   localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;
   localparam logic [6:0] MAJ_JAL    = 7'b1101111;
   localparam logic [6:0] MAJ_JALR   = 7'b1100111;
   localparam logic [6:0] MAJ_BRANCH = 7'b1100011;
   localparam logic [6:0] MAJ_LOAD   = 7'b0000011;
   localparam logic [6:0] MAJ_STORE  = 7'b0100011;
   localparam logic [6:0] MAJ_OPIMM  = 7'b0010011;
   localparam logic [6:0] MAJ_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      ST_FETCH     = 2'd0,
      ST_WAIT      = 2'd1,
      ST_ISSUE     = 2'd2,
      ST_JALR_WAIT = 2'd3
   } state_e;

   function automatic logic is_branch(input logic [6:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

endpackage

// File: rtl/issue_controller_decoder.sv
// issue_controller_decoder
//   Purely combinational RV32I decoder.
//   inst   : raw 32-bit instruction
//   opcode : internal opcode enum (0 = illegal)
//   rs1/rs2/rd : register fields, zeroed where the format has none
//   imm    : sign-extended immediate for the format (shamt for shifts)
module issue_controller_decoder
   import issue_controller_pkg::*;
#(
   parameter int OPCODE_W = 7
) (
   input  logic [31:0]         inst,
   output logic [OPCODE_W-1:0] opcode,
   output logic [4:0]          rs1,
   output logic [4:0]          rs2,
   output logic [4:0]          rd,
   output logic [31:0]         imm
);

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign f3    = inst[14:12];
   assign f7    = inst[31:25];
   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      op  = OP_ILLEGAL;
      rs1 = inst[19:15];
      rs2 = inst[24:20];
      rd  = inst[11:7];
      imm = '0;
      case (inst[6:0])
         MAJ_LUI, MAJ_AUIPC: begin
            op  = (inst[6:0] == MAJ_LUI) ? OP_LUI : OP_AUIPC;
            rs1 = '0; rs2 = '0; imm = imm_u;
         end
         MAJ_JAL: begin
            op = OP_JAL; rs1 = '0; rs2 = '0; imm = imm_j;
         end
         MAJ_JALR: begin
            if (f3 == 3'd0) op = OP_JALR;
            rs2 = '0; imm = imm_i;
         end
         MAJ_BRANCH: begin
            case (f3)
               3'd0: op = OP_BEQ;
               3'd1: op = OP_BNE;
               3'd4: op = OP_BLT;
               3'd5: op = OP_BGE;
               3'd6: op = OP_BLTU;
               3'd7: op = OP_BGEU;
               default: op = OP_ILLEGAL;
            endcase
            rd = '0; imm = imm_b;
         end
         MAJ_LOAD: begin
            case (f3)
               3'd0: op = OP_LB;
               3'd1: op = OP_LH;
               3'd2: op = OP_LW;
               3'd4: op = OP_LBU;
               3'd5: op = OP_LHU;
               default: op = OP_ILLEGAL;
            endcase
            rs2 = '0; imm = imm_i;
         end
         MAJ_STORE: begin
            case (f3)
               3'd0: op = OP_SB;
               3'd1: op = OP_SH;
               3'd2: op = OP_SW;
               default: op = OP_ILLEGAL;
            endcase
            rd = '0; imm = imm_s;
         end
         MAJ_OPIMM: begin
            rs2 = '0; imm = imm_i;
            case (f3)
               3'd0: op = OP_ADDI;
               3'd2: op = OP_SLTI;
               3'd3: op = OP_SLTIU;
               3'd4: op = OP_XORI;
               3'd6: op = OP_ORI;
               3'd7: op = OP_ANDI;
               3'd1: if (f7 == 7'b0000000) op = OP_SLLI;
               3'd5: begin
                  if (f7 == 7'b0000000)      op = OP_SRLI;
                  else if (f7 == 7'b0100000) op = OP_SRAI;
               end
               default: op = OP_ILLEGAL;
            endcase
            // shifts carry only the shift amount
            if (f3 == 3'd1 || f3 == 3'd5) imm = {27'b0, inst[24:20]};
         end
         MAJ_OP: begin
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'd0: op = OP_ADD;
                  3'd1: op = OP_SLL;
                  3'd2: op = OP_SLT;
                  3'd3: op = OP_SLTU;
                  3'd4: op = OP_XOR;
                  3'd5: op = OP_SRL;
                  3'd6: op = OP_OR;
                  default: op = OP_AND;
               endcase
            end else if (f7 == 7'b0100000) begin
               if (f3 == 3'd0)      op = OP_SUB;
               else if (f3 == 3'd5) op = OP_SRA;
            end
         end
         default: op = OP_ILLEGAL;
      endcase
   end

   assign opcode = OPCODE_W'(op);

endmodule

// File: rtl/issue_controller.sv
// issue_controller
//   Issue-stage front end: owns the PC, fetches one instruction at a time,
//   decodes it and hands the packet plus predicted next PC to dispatch.
//   Optional macro ISSUE_BTFN_PREDICT_EN: backward branches predicted taken;
//   without it every branch is predicted not taken.
// Ports:
//   clk_in, rst_in (async, active low)
//   ic_req_*   : fetch request handshake (addr = pc)
//   ic_resp_*  : single-cycle instruction return
//   iss_*      : decoded packet handshake toward the dispatcher
//   jalr_done/jalr_target : resolved jalr target from the ALU
//   flush_valid/flush_pc  : mispredict redirect from the RoB
module issue_controller
   import issue_controller_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          OPCODE_W = 7
) (
   input  logic                clk_in,
   input  logic                rst_in,
   output logic                ic_req_valid,
   input  logic                ic_req_ready,
   output logic [31:0]         ic_req_addr,
   input  logic                ic_resp_valid,
   input  logic [31:0]         ic_resp_inst,
   output logic                iss_valid,
   input  logic                iss_ready,
   output logic [OPCODE_W-1:0] iss_opcode,
   output logic [4:0]          iss_rs1,
   output logic [4:0]          iss_rs2,
   output logic [4:0]          iss_rd,
   output logic [31:0]         iss_imm,
   output logic [31:0]         iss_pc,
   output logic                iss_pred_taken,
   input  logic                jalr_done,
   input  logic [31:0]         jalr_target,
   input  logic                flush_valid,
   input  logic [31:0]         flush_pc
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q;
   logic        discard_q, discard_d;  // one stale icache response still owed
   logic        live_q;                // holds fetch off during/just out of reset

   logic [OPCODE_W-1:0] dec_op;
   logic [31:0]         dec_imm;
   logic [6:0]          op7;
   logic                is_br, pred_taken, req_fire, iss_fire;

   issue_controller_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
      .inst   (inst_q),
      .opcode (dec_op),
      .rs1    (iss_rs1),
      .rs2    (iss_rs2),
      .rd     (iss_rd),
      .imm    (dec_imm)
   );

   assign op7   = 7'(dec_op);
   assign is_br = is_branch(op7);

`ifdef ISSUE_BTFN_PREDICT_EN
   assign pred_taken = is_br && dec_imm[31];
`else
   assign pred_taken = 1'b0;
`endif

   // No new request while a stale response is still in flight.
   assign ic_req_valid   = live_q && (state_q == ST_FETCH) && !discard_q;
   assign ic_req_addr    = pc_q;
   assign iss_valid      = (state_q == ST_ISSUE);
   assign iss_opcode     = dec_op;
   assign iss_imm        = dec_imm;
   assign iss_pc         = pc_q;
   assign iss_pred_taken = iss_valid && pred_taken;

   assign req_fire = ic_req_valid && ic_req_ready;
   assign iss_fire = iss_valid && iss_ready;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      if (discard_q && ic_resp_valid) discard_d = 1'b0;
      case (state_q)
         ST_FETCH: if (req_fire) state_d = ST_WAIT;
         ST_WAIT:  if (ic_resp_valid) state_d = ST_ISSUE;
         ST_ISSUE: begin
            if (iss_fire) begin
               state_d = ST_FETCH;
               if (op7 == OP_JAL)                pc_d = pc_q + dec_imm;
               else if (is_br && pred_taken)     pc_d = pc_q + dec_imm;
               else if (op7 == OP_JALR)          state_d = ST_JALR_WAIT;
               else                              pc_d = pc_q + 32'd4;
            end
         end
         ST_JALR_WAIT: begin
            if (jalr_done) begin
               pc_d    = jalr_target & ~32'd1;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
      // Flush wins over everything; remember any response that is still owed
      // (in WAIT without a response this cycle, or a request accepted now).
      if (flush_valid) begin
         pc_d      = flush_pc;
         state_d   = ST_FETCH;
         discard_d = (discard_q && !ic_resp_valid) ||
                     (state_q == ST_WAIT && !ic_resp_valid) || req_fire;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         discard_q <= 1'b0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         live_q    <= 1'b1;
         if (state_q == ST_WAIT && ic_resp_valid && !flush_valid) inst_q <= ic_resp_inst;
      end
   end

endmodule

// File: tb/tb_issue_controller.sv
module tb_issue_controller;

   logic        clk_in = 1'b0, rst_in = 1'b0;
   logic        ic_req_valid, ic_req_ready = 1'b0;
   logic [31:0] ic_req_addr;
   logic        ic_resp_valid = 1'b0;
   logic [31:0] ic_resp_inst = '0;
   logic        iss_valid, iss_ready = 1'b0;
   logic [6:0]  iss_opcode;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic [31:0] iss_imm, iss_pc;
   logic        iss_pred_taken;
   logic        jalr_done = 1'b0;
   logic [31:0] jalr_target = '0;
   logic        flush_valid = 1'b0;
   logic [31:0] flush_pc = '0;

   int checks = 0, errors = 0;

`ifdef ISSUE_BTFN_PREDICT_EN
   localparam logic [31:0] BR_PRED = 32'd1;
   localparam logic [31:0] BR_NEXT = 32'h38;
`else
   localparam logic [31:0] BR_PRED = 32'd0;
   localparam logic [31:0] BR_NEXT = 32'h44;
`endif

   issue_controller dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
      .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_imm(iss_imm),
      .iss_pc(iss_pc), .iss_pred_taken(iss_pred_taken),
      .jalr_done(jalr_done), .jalr_target(jalr_target),
      .flush_valid(flush_valid), .flush_pc(flush_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for a request, check its address, accept it.
   task automatic req(input string tag, input logic [31:0] addr);
      int n = 0;
      do begin @(negedge clk_in); n++; end while (!ic_req_valid && n < 30);
      chk({tag, " req_valid"}, 32'(ic_req_valid), 32'd1);
      chk({tag, " req_addr"}, ic_req_addr, addr);
      ic_req_ready = 1'b1;
      @(negedge clk_in);
      ic_req_ready = 1'b0;
      chk({tag, " no req while waiting"}, 32'(ic_req_valid), 32'd0);
   endtask

   task automatic resp(input logic [31:0] inst);
      ic_resp_valid = 1'b1;
      ic_resp_inst  = inst;
      @(negedge clk_in);
      ic_resp_valid = 1'b0;
   endtask

   task automatic issue(input string tag);
      chk({tag, " iss_valid"}, 32'(iss_valid), 32'd1);
      iss_ready = 1'b1;
      @(negedge clk_in);
      iss_ready = 1'b0;
   endtask

   initial begin
      // reset
      repeat (2) @(negedge clk_in);
      chk("rst ic_req_valid", 32'(ic_req_valid), 32'd0);
      chk("rst iss_valid", 32'(iss_valid), 32'd0);
      chk("rst pred_taken", 32'(iss_pred_taken), 32'd0);
      chk("rst req_addr", ic_req_addr, 32'h0);
      rst_in = 1'b1;

      // addi x1,x0,5 at 0; a jalr_done here must be ignored
      req("addi", 32'h0);
      resp(32'h0050_0093);
      chk("addi opcode", 32'(iss_opcode), 32'd19);
      chk("addi rd", 32'(iss_rd), 32'd1);
      chk("addi rs1", 32'(iss_rs1), 32'd0);
      chk("addi imm", iss_imm, 32'd5);
      chk("addi pc", iss_pc, 32'h0);
      jalr_done = 1'b1; jalr_target = 32'h999;
      issue("addi");
      jalr_done = 1'b0;

      // jal x0,+12 at 4 -> 0x10
      req("jal12", 32'h4);
      resp(32'h00C0_006F);
      chk("jal12 opcode", 32'(iss_opcode), 32'd3);
      chk("jal12 imm", iss_imm, 32'd12);
      issue("jal12");

      // jal x0,+8 at 0x10 -> 0x18, again -> 0x20
      req("jal8a", 32'h10);
      resp(32'h0080_006F);
      chk("jal8a opcode", 32'(iss_opcode), 32'd3);
      chk("jal8a imm", iss_imm, 32'd8);
      issue("jal8a");
      req("jal8b", 32'h18);
      resp(32'h0080_006F);
      issue("jal8b");

      // jalr x1,0(x1) at 0x20: no fetch until resolved
      req("jalr", 32'h20);
      resp(32'h0000_80E7);
      chk("jalr opcode", 32'(iss_opcode), 32'd4);
      chk("jalr rd", 32'(iss_rd), 32'd1);
      chk("jalr rs1", 32'(iss_rs1), 32'd1);
      chk("jalr pc", iss_pc, 32'h20);
      issue("jalr");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         chk("jalr wait no req", 32'(ic_req_valid), 32'd0);
      end
      jalr_done = 1'b1; jalr_target = 32'h105;
      @(negedge clk_in);
      jalr_done = 1'b0;

      // flush while waiting: stale response dropped
      req("jalr tgt", 32'h104);
      flush_valid = 1'b1; flush_pc = 32'h200;
      @(negedge clk_in);
      flush_valid = 1'b0;
      chk("flush iss_valid", 32'(iss_valid), 32'd0);
      chk("flush stale pending no req", 32'(ic_req_valid), 32'd0);
      resp(32'h0050_0093);
      chk("stale resp no packet", 32'(iss_valid), 32'd0);

      // flush coinciding with an issue handshake: pc from flush
      req("flush tgt", 32'h200);
      resp(32'h0080_006F);
      chk("flushhs pc", iss_pc, 32'h200);
      iss_ready = 1'b1; flush_valid = 1'b1; flush_pc = 32'h40;
      @(negedge clk_in);
      iss_ready = 1'b0; flush_valid = 1'b0;
      chk("flushhs iss_valid drop", 32'(iss_valid), 32'd0);

      // beq x0,x0,-8 at 0x40 with 5 cycles of backpressure
      req("beq", 32'h40);
      resp(32'hFE00_0CE3);
      for (int i = 0; i < 5; i++) begin
         chk("stall iss_valid", 32'(iss_valid), 32'd1);
         chk("stall opcode", 32'(iss_opcode), 32'd5);
         chk("stall imm", iss_imm, 32'hFFFF_FFF8);
         chk("stall pc", iss_pc, 32'h40);
         chk("stall pred", 32'(iss_pred_taken), BR_PRED);
         chk("stall no req", 32'(ic_req_valid), 32'd0);
         @(negedge clk_in);
      end
      issue("beq");
      req("beq next", BR_NEXT);
      resp(32'h0050_0093);
      issue("after beq");

      // illegal word at top of memory; pc wraps to 0
      flush_valid = 1'b1; flush_pc = 32'hFFFF_FFFC;
      @(negedge clk_in);
      flush_valid = 1'b0;
      req("illegal", 32'hFFFF_FFFC);
      resp(32'hFFFF_FFFF);
      chk("illegal opcode", 32'(iss_opcode), 32'd0);
      issue("illegal");
      req("wrap", 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
